// File: rtl/axis_pkg.sv
// Shared definitions for the buffered AXI-Stream broadcaster:
// packet-tracking FSM states and the FIFO pointer-width helper.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } bcast_state_t;

  // Pointer width for a DEPTH-entry FIFO: address bits plus one wrap bit
  // that tells a full FIFO apart from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO holding one output stream's beats. full/empty come
// straight from registered pointers, so they never depend on this cycle's
// push/pop requests.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra bit.
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PW'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axis_broadcast_buffered.sv
// Broadcasts one AXI-Stream input to NUM_STREAMS outputs, each behind its
// own FIFO so a slow consumer only stalls the input once its FIFO fills.
// The destination set is sampled at the first beat of a packet and held
// until tlast. Optional per-output packet counters: AXIS_BROADCAST_STATS_EN.
module axis_broadcast_buffered
  import axis_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS    = 2,
  parameter int DEPTH          = 4
) (
  input  logic                                     clk,
  input  logic                                     sreset,
  output logic                                     axis_i_tready,
  input  logic                                     axis_i_tvalid,
  input  logic                                     axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]                  axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]                axis_i_tuser,
  input  logic [NUM_STREAMS-1:0]                   axis_o_tready,
  output logic [NUM_STREAMS-1:0]                   axis_o_tvalid,
  output logic [NUM_STREAMS-1:0]                   axis_o_tlast,
  output logic [NUM_STREAMS*AXIS_BYTES*8-1:0]      axis_o_tdata,
  output logic [NUM_STREAMS*AXIS_USER_BITS-1:0]    axis_o_tuser,
  input  logic [NUM_STREAMS-1:0]                   enable_mask,
  output logic [NUM_STREAMS-1:0]                   active_mask
`ifdef AXIS_BROADCAST_STATS_EN
  ,
  output logic [NUM_STREAMS*32-1:0]                pkt_count
`endif
);

  localparam int DW    = AXIS_BYTES * 8;
  localparam int UW    = AXIS_USER_BITS;
  localparam int PAY_W = 1 + UW + DW;

  bcast_state_t           state;
  bcast_state_t           state_next;
  logic [NUM_STREAMS-1:0] mask_q;
  logic [NUM_STREAMS-1:0] mask_next;
  logic [NUM_STREAMS-1:0] eff_mask;
  logic [NUM_STREAMS-1:0] full;
  logic [NUM_STREAMS-1:0] empty;
  logic [NUM_STREAMS-1:0] push;
  logic [NUM_STREAMS-1:0] pop;
  logic [PAY_W-1:0]       beat;
  logic                   accept;

  assign eff_mask      = (state == PKT) ? mask_q : enable_mask;
  assign axis_i_tready = !sreset && (&(~eff_mask | ~full));
  assign accept        = axis_i_tvalid && axis_i_tready;
  assign push          = {NUM_STREAMS{accept}} & eff_mask;
  assign beat          = {axis_i_tlast, axis_i_tuser, axis_i_tdata};
  assign active_mask   = (state == PKT && !sreset) ? mask_q : '0;

  // Packet tracking: latch the destination set on a non-final first beat.
  always_comb begin
    state_next = state;
    mask_next  = mask_q;
    if (accept) begin
      if (axis_i_tlast) begin
        state_next = IDLE;
      end else if (state == IDLE) begin
        state_next = PKT;
        mask_next  = eff_mask;
      end
    end
  end

  // FSM and latched-mask registers.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state  <= IDLE;
      mask_q <= '0;
    end else begin
      state  <= state_next;
      mask_q <= mask_next;
    end
  end

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_stream
    logic [PAY_W-1:0] dout;

    axis_sync_fifo #(
      .WIDTH(PAY_W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .sreset (sreset),
      .push   (push[i]),
      .din    (beat),
      .pop    (pop[i]),
      .dout   (dout),
      .full   (full[i]),
      .empty  (empty[i])
    );

    assign axis_o_tvalid[i]          = !empty[i] && !sreset;
    assign pop[i]                    = axis_o_tvalid[i] && axis_o_tready[i];
    assign axis_o_tlast[i]           = dout[PAY_W-1];
    assign axis_o_tuser[i*UW +: UW]  = dout[DW +: UW];
    assign axis_o_tdata[i*DW +: DW]  = dout[DW-1:0];

`ifdef AXIS_BROADCAST_STATS_EN
    logic [31:0] cnt;

    // Count packets completed on this output; wraps at 2^32.
    always_ff @(posedge clk) begin
      if (sreset) cnt <= '0;
      else if (pop[i] && dout[PAY_W-1]) cnt <= cnt + 32'd1;
    end

    assign pkt_count[i*32 +: 32] = cnt;
`else
    // Statistics disabled: no counters in this build.
`endif
  end

endmodule

// File: tb/tb_axis_broadcast_buffered.sv
// Directed bench for axis_broadcast_buffered with three outputs and
// four-entry FIFOs. Counter checks compile in with AXIS_BROADCAST_STATS_EN.
module tb_axis_broadcast_buffered;

  localparam int N = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         sreset;
  logic         axis_i_tready;
  logic         axis_i_tvalid;
  logic         axis_i_tlast;
  logic [7:0]   axis_i_tdata;
  logic [0:0]   axis_i_tuser;
  logic [N-1:0] axis_o_tready;
  logic [N-1:0] axis_o_tvalid;
  logic [N-1:0] axis_o_tlast;
  logic [N*8-1:0] axis_o_tdata;
  logic [N-1:0] axis_o_tuser;
  logic [N-1:0] enable_mask;
  logic [N-1:0] active_mask;
`ifdef AXIS_BROADCAST_STATS_EN
  logic [N*32-1:0] pkt_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] got0[$];
  logic [8:0] got1[$];
  logic [8:0] got2[$];

  always #5 clk = ~clk;

  axis_broadcast_buffered #(
    .AXIS_BYTES(1),
    .AXIS_USER_BITS(1),
    .NUM_STREAMS(N),
    .DEPTH(D)
  ) dut (
    .clk           (clk),
    .sreset        (sreset),
    .axis_i_tready (axis_i_tready),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tlast  (axis_i_tlast),
    .axis_i_tdata  (axis_i_tdata),
    .axis_i_tuser  (axis_i_tuser),
    .axis_o_tready (axis_o_tready),
    .axis_o_tvalid (axis_o_tvalid),
    .axis_o_tlast  (axis_o_tlast),
    .axis_o_tdata  (axis_o_tdata),
    .axis_o_tuser  (axis_o_tuser),
    .enable_mask   (enable_mask),
    .active_mask   (active_mask)
`ifdef AXIS_BROADCAST_STATS_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  // Record every beat each output hands over, as {tlast, tdata}.
  always @(posedge clk) begin
    if (!sreset) begin
      if (axis_o_tvalid[0] && axis_o_tready[0]) got0.push_back({axis_o_tlast[0], axis_o_tdata[7:0]});
      if (axis_o_tvalid[1] && axis_o_tready[1]) got1.push_back({axis_o_tlast[1], axis_o_tdata[15:8]});
      if (axis_o_tvalid[2] && axis_o_tready[2]) got2.push_back({axis_o_tlast[2], axis_o_tdata[23:16]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] out_beat(input int s);
    return {axis_o_tvalid[s], axis_o_tlast[s], axis_o_tdata[s*8 +: 8]};
  endfunction

  task automatic clear_got();
    got0.delete();
    got1.delete();
    got2.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = d;
    axis_i_tlast  = last;
    axis_i_tuser  = d[0];
    n = 0;
    @(negedge clk);
    while (!axis_i_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!axis_i_tready) chk("accept_timeout", 32'(axis_i_tready), 32'd1);
    @(posedge clk);
    #1;
    axis_i_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_beat;
    sreset        = 1'b1;
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    axis_i_tdata  = 8'h00;
    axis_i_tuser  = 1'b0;
    axis_o_tready = 3'b111;
    enable_mask   = 3'b111;

    // Reset state.
    idle(2);
    @(negedge clk);
    chk("rst_tready", 32'(axis_i_tready), 32'd0);
    chk("rst_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("rst_active", 32'(active_mask), 32'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 32'(axis_i_tready), 32'd1);
    @(posedge clk);
    #1;

    // Four-beat broadcast to all outputs, one cycle latency.
    for (int k = 0; k < 4; k++) begin
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = 8'h10 + 8'(k);
      axis_i_tlast  = (k == 3);
      axis_i_tuser  = 1'b0;
      @(negedge clk);
      chk("t1_tready", 32'(axis_i_tready), 32'd1);
      if (k > 0) begin
        exp_beat = {1'b1, 1'b0, 8'h10 + 8'(k - 1)};
        for (int s = 0; s < N; s++) chk("t1_out", 32'(out_beat(s)), 32'(exp_beat));
      end
      @(posedge clk);
      #1;
    end
    axis_i_tvalid = 1'b0;
    @(negedge clk);
    for (int s = 0; s < N; s++) chk("t1_last", 32'(out_beat(s)), 32'h313);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_drained", 32'(axis_o_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // Output 1 stalled: its FIFO fills after four beats and blocks input.
    clear_got();
    axis_o_tready = 3'b101;
    for (int k = 0; k < 4; k++) send_beat(8'h20 + 8'(k), 1'b0);
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = 8'h24;
    axis_i_tlast  = 1'b0;
    @(negedge clk);
    chk("t2_stall_tready", 32'(axis_i_tready), 32'd0);
    chk("t2_out1_hold", 32'(out_beat(1)), 32'h220);
    idle(2);
    @(negedge clk);
    chk("t2_got0", 32'(got0.size()), 32'd4);
    chk("t2_got2", 32'(got2.size()), 32'd4);
    chk("t2_got1", 32'(got1.size()), 32'd0);
    chk("t2_still_stalled", 32'(axis_i_tready), 32'd0);
    @(posedge clk);
    #1;
    axis_o_tready = 3'b111;
    @(negedge clk);
    chk("t2_tready_registered", 32'(axis_i_tready), 32'd0);
    send_beat(8'h24, 1'b0);
    send_beat(8'h25, 1'b0);
    send_beat(8'h26, 1'b0);
    send_beat(8'h27, 1'b1);
    idle(10);
    chk("t2_got1_all", 32'(got1.size()), 32'd8);
    chk("t2_got0_all", 32'(got0.size()), 32'd8);
    chk("t2_got1_first", 32'(got1.size() > 0 ? got1[0] : 9'h1ff), 32'h020);
    chk("t2_got1_last", 32'(got1.size() > 7 ? got1[7] : 9'h1ff), 32'h127);
    chk("t2_got2_last", 32'(got2.size() > 7 ? got2[7] : 9'h1ff), 32'h127);

    // Mask latched at packet start; mid-packet changes ignored.
    clear_got();
    enable_mask = 3'b101;
    send_beat(8'h30, 1'b0);
    @(negedge clk);
    chk("t3_active", 32'(active_mask), 32'h5);
    @(posedge clk);
    #1;
    enable_mask = 3'b010;
    send_beat(8'h31, 1'b0);
    @(negedge clk);
    chk("t3_active_hold", 32'(active_mask), 32'h5);
    @(posedge clk);
    #1;
    send_beat(8'h32, 1'b1);
    @(negedge clk);
    chk("t3_active_idle", 32'(active_mask), 32'h0);
    @(posedge clk);
    #1;
    send_beat(8'h40, 1'b1);
    idle(6);
    chk("t3_got0", 32'(got0.size()), 32'd3);
    chk("t3_got2", 32'(got2.size()), 32'd3);
    chk("t3_got0_last", 32'(got0.size() > 2 ? got0[2] : 9'h1ff), 32'h132);
    chk("t3_got1", 32'(got1.size()), 32'd1);
    chk("t3_got1_beat", 32'(got1.size() > 0 ? got1[0] : 9'h1ff), 32'h140);

    // Empty mask: beats are swallowed, input always ready.
    clear_got();
    enable_mask = 3'b000;
    for (int k = 0; k < 3; k++) begin
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = 8'h50 + 8'(k);
      axis_i_tlast  = (k == 2);
      @(negedge clk);
      chk("t4_tready", 32'(axis_i_tready), 32'd1);
      chk("t4_tvalid", 32'(axis_o_tvalid), 32'd0);
      @(posedge clk);
      #1;
    end
    axis_i_tvalid = 1'b0;
    idle(4);
    chk("t4_none", 32'(got0.size() + got1.size() + got2.size()), 32'd0);
    chk("t4_active", 32'(active_mask), 32'd0);
    enable_mask = 3'b001;
    send_beat(8'h45, 1'b1);
    idle(4);
    chk("t4_idle_got0", 32'(got0.size()), 32'd1);
    chk("t4_idle_got1", 32'(got1.size()), 32'd0);

    // Reset mid-packet discards buffered beats and restarts packet tracking.
    clear_got();
    axis_o_tready = 3'b000;
    enable_mask   = 3'b111;
    send_beat(8'h50, 1'b0);
    send_beat(8'h51, 1'b0);
    enable_mask = 3'b001;
    @(negedge clk);
    chk("t5_buffered", 32'(axis_o_tvalid), 32'h7);
    chk("t5_active", 32'(active_mask), 32'h7);
    @(posedge clk);
    #1;
    sreset = 1'b1;
    @(negedge clk);
    chk("t5_rst_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("t5_rst_tready", 32'(axis_i_tready), 32'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    @(negedge clk);
    chk("t5_post_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("t5_post_active", 32'(active_mask), 32'd0);
    @(posedge clk);
    #1;
    axis_o_tready = 3'b111;
    send_beat(8'h60, 1'b0);
    send_beat(8'h61, 1'b1);
    idle(4);
    chk("t5_got0", 32'(got0.size()), 32'd2);
    chk("t5_got0_first", 32'(got0.size() > 0 ? got0[0] : 9'h1ff), 32'h060);
    chk("t5_got0_last", 32'(got0.size() > 1 ? got0[1] : 9'h1ff), 32'h161);
    chk("t5_got12", 32'(got1.size() + got2.size()), 32'd0);

`ifdef AXIS_BROADCAST_STATS_EN
    // Per-output packet counters.
    sreset = 1'b1;
    idle(1);
    sreset = 1'b0;
    enable_mask = 3'b011;
    for (int p = 0; p < 3; p++) begin
      send_beat(8'h70 + 8'(p), 1'b0);
      send_beat(8'h78 + 8'(p), 1'b1);
    end
    idle(4);
    chk("stats_0", pkt_count[31:0], 32'd3);
    chk("stats_1", pkt_count[63:32], 32'd3);
    chk("stats_2", pkt_count[95:64], 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_broadcast_buffered.md
AXIS_BROADCAST_BUFFERED -- requirements
Module: axis_broadcast_buffered

Interface
REQ-001 SHALL have parameter AXIS_BYTES, default 1: tdata width in bytes.
REQ-002 SHALL have parameter AXIS_USER_BITS, default 1: tuser width.
REQ-003 SHALL have parameter NUM_STREAMS, default 2: output channel count, 1..32.
REQ-004 SHALL have parameter DEPTH, default 4: per-output buffer entries, power of two, >=2.
REQ-005 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port sreset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port group axis_i_tready out 1, axis_i_tvalid in 1, axis_i_tlast in 1, axis_i_tdata in AXIS_BYTES*8, axis_i_tuser in AXIS_USER_BITS: input stream.
REQ-008 SHALL have port group axis_o_tready in NUM_STREAMS, axis_o_tvalid out NUM_STREAMS, axis_o_tlast out NUM_STREAMS, axis_o_tdata out NUM_STREAMS*AXIS_BYTES*8, axis_o_tuser out NUM_STREAMS*AXIS_USER_BITS: packed outputs, stream i at slice i.
REQ-009 SHALL have port enable_mask  in  NUM_STREAMS  requested destination set.
REQ-010 SHALL have port active_mask  out  NUM_STREAMS  destination set of the packet in flight.

Function
REQ-011 SHALL give each output stream an independent DEPTH-entry FIFO, so a stalled output delays only itself until its FIFO fills.
REQ-012 SHALL run a two-state FSM: IDLE (between packets) and PKT (mid-packet).
REQ-013 SHALL use eff_mask = enable_mask in IDLE and the latched mask in PKT.
REQ-014 SHALL drive axis_i_tready = 1 when every stream set in eff_mask has a non-full FIFO.
REQ-015 SHALL compute fullness from registered fill state only, with no combinational path from axis_o_tready to axis_i_tready; a full FIFO popped this cycle accepts again next cycle.
REQ-016 SHALL treat a beat as accepted when axis_i_tvalid && axis_i_tready, and push it into exactly the FIFOs selected by eff_mask.
REQ-017 SHALL, on an accepted beat with tlast=0 in IDLE, latch eff_mask and enter PKT.
REQ-018 SHALL, on an accepted beat with tlast=1, return to IDLE; a one-beat packet never leaves IDLE.
REQ-019 SHALL ignore enable_mask changes while in PKT.
REQ-020 SHALL, when eff_mask is all-zero, hold axis_i_tready=1 and discard beats, with normal FSM tracking.
REQ-021 SHALL present an accepted beat on axis_o_tvalid[i] the cycle after acceptance when FIFO i was empty.
REQ-022 SHALL sustain one beat per cycle per stream when outputs are ready.
REQ-023 SHALL keep axis_o_tvalid[i] and its data stable until axis_o_tready[i] is high.
REQ-024 SHALL wrap FIFO pointers modulo DEPTH, distinguishing full from empty by an extra pointer bit; simultaneous push and pop on a non-full FIFO leaves the fill level unchanged.
REQ-025 SHALL drive active_mask = latched mask in PKT, else 0.

Reset
REQ-026 SHALL, while sreset is high, empty all FIFOs, set the FSM to IDLE, clear the latched mask, drive axis_o_tvalid=0, active_mask=0 and axis_i_tready=0.
REQ-027 SHALL discard partially broadcast packets on reset mid-packet; the first beat after reset is treated as a packet start.

Configuration
REQ-028 SHALL, with macro AXIS_BROADCAST_STATS_EN defined, add output pkt_count (NUM_STREAMS*32) holding one counter per stream of tlast beats popped on output i, wrapping at 2^32 and cleared by sreset.
REQ-029 SHALL, without AXIS_BROADCAST_STATS_EN, omit the pkt_count port and logic, with all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, PKT) and the pointer-width function clog2(DEPTH)+1 in shared package axis_pkg.
REQ-031 SHALL instantiate sub-module axis_sync_fifo once per output stream, with a push/pop/full/empty interface and registered outputs.

Verification
REQ-032 SHALL cover: NUM_STREAMS=3, mask=111, all ready, 4-beat packet 0x10..0x13 -> each output shows 0x10..0x13 one cycle after acceptance, tlast on 0x13.
REQ-033 SHALL cover: DEPTH=4, output 1 held not-ready, 8-beat packet -> 4 beats accepted, then tready=0; outputs 0 and 2 receive 4 beats; releasing output 1 lets all 8 beats complete.
REQ-034 SHALL cover: mask=101 at the first beat, changed to 010 mid-packet -> whole packet goes only to outputs 0 and 2, active_mask=101; the next packet goes to output 1.
REQ-035 SHALL cover: mask=000, 3-beat packet -> tready=1 every cycle, no output valid, FSM back in IDLE.
REQ-036 SHALL cover: sreset asserted after beat 2 of 5 -> all tvalid=0 next cycle; a fresh 2-beat packet after reset is delivered intact.
REQ-037 SHALL cover, with AXIS_BROADCAST_STATS_EN: 3 packets broadcast to mask=011 -> pkt_count = {0,3,3}.
